change_capture_fifo: RTL and testbench
======================================

Name: change_capture_fifo

Overview:
- Downstream consumer of the 4-bit registered accumulator/operand stage.
- Watches that stage's data output every cycle and records each new value into a small FIFO.
- Drains the recorded values to the next stage over a valid/ready handshake.
- Gives the test harness and the next stage a loss-free history of value changes. Also exposes fill level and a sticky overflow flag.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CW, $clog2(DEPTH)+1, width of the count output (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset.
- data_in  input  4  registered data output of the upstream stage.
- capture_en  input  1  enables change detection/capture this cycle.
- clr_ovf  input  1  clears the sticky overflow flag.
- out_ready  input  1  consumer ready.
- out_valid  output  1  FIFO non-empty; out_data is valid.
- out_data  output  4  oldest stored value (first-word fall-through).
- count  output  CW  number of stored entries, 0..DEPTH.
- overflow  output  1  sticky flag: a capture was lost or overwritten.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset (rst=1 at an edge): count=0, rd/wr pointers=0, out_valid=0, overflow=0, last_vld=0, last_val=4'h0. Memory contents are don't-care.
- Reset has priority over every other input. Reset mid-drain discards all entries; out_valid is 0 in the cycle after the reset edge.
- Change detect: push_req = capture_en && (!last_vld || data_in != last_val).
  - The first enabled sample after reset is always captured.
  - With capture_en=0, last_val/last_vld hold.
- On any cycle with push_req=1: last_val<=data_in, last_vld<=1. This applies even if the entry is dropped, so repeated identical values never retry.
- Pop: pop = out_valid && out_ready. The rd pointer advances; the entry is consumed at that edge.
- out_valid = (count != 0), decoded from the count register; no combinational path from inputs.
- out_data = mem[rd_ptr], read combinationally from the register array.
  - Value is undefined (bench ignores it) when out_valid=0.
  - Must stay stable while out_valid=1 and out_ready=0.
- Push accepted when count<DEPTH, or when count==DEPTH and pop=1 in the same cycle (slot freed, no overflow).
- Full, no pop, push_req=1 (default build): new value dropped, overflow<=1, count stays DEPTH.
- Empty with push_req=1: entry written; out_valid rises the next cycle (latency 1 from data_in change to out_valid). No pop can occur that cycle.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- Overflow: set on a loss event; cleared by clr_ovf.
  - Set wins if clr_ovf and a loss event coincide.
  - Cleared otherwise only by reset.
- No X propagation: all outputs are driven from reset registers.

Optional Feature:
- Macro: CHANGE_CAPTURE_FIFO_OVERWRITE_EN.
- Defined: on full with no pop and push_req=1, the oldest entry is overwritten.
  - The rd pointer advances and the new value is written at the wr pointer.
  - count stays DEPTH; overflow<=1.
  - The stream keeps the newest DEPTH changes.
- Undefined: drop-newest behaviour as in Behaviour.
- Either way, overflow is set on the loss event.

Test Plan:
- Reset then first capture: rst=1 for 2 cycles, then capture_en=1, data_in=4'h0 constant, out_ready=0. Expect count 0→1 one edge after capture, and no further pushes. out_valid=1, out_data=4'h0.
- Change filtering: capture_en=1, data_in sequence 3,3,5,5,5,A, out_ready=0. Expect count=3 and entries 3,5,A. Drain with out_ready=1: out_data 3,5,A on consecutive cycles, then out_valid=0.
- Full/drop (DEPTH=4, default build): push 1,2,3,4,5 with out_ready=0. Expect count=4, overflow=1, drain yields 1,2,3,4. Then clr_ovf=1 for 1 cycle → overflow=0.
- Full with simultaneous pop: FIFO holds 1,2,3,4; data_in→6 with out_ready=1 in the same cycle. Expect 1 popped, 6 stored, count=4, overflow=0. Drain yields 2,3,4,6.
- Backpressure stability: FIFO holds 9,C; out_ready=0 for 5 cycles. Expect out_data=9 steady and out_valid=1. Then out_ready=1 → 9 then C.
- Overwrite build (CHANGE_CAPTURE_FIFO_OVERWRITE_EN): push 1..6, no pops. Expect count=4, overflow=1, drain yields 3,4,5,6.
- Reset mid-operation: FIFO holds 2 entries, assert rst for 1 cycle with out_ready=1. Expect count=0, out_valid=0, overflow=0 next cycle. The next enabled sample is captured even if equal to the prior last_val.

Source files
------------

// File: rtl/change_capture_fifo.sv
// Change-capture FIFO: records each new upstream value and drains it over valid/ready.
// Optional build macro CHANGE_CAPTURE_FIFO_OVERWRITE_EN: overwrite oldest entry when full.
module change_capture_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    data_in,
  input  logic          capture_en,
  input  logic          clr_ovf,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [3:0]    out_data,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = 4;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] last_val_q, last_val_d;
  logic          last_vld_q, last_vld_d;

  logic push_req;
  logic pop;
  logic full;
  logic loss;
  logic wr_en;
  logic rd_adv;

  // Change detection, handshake and next-state computation
  always_comb begin
    push_req   = capture_en && (!last_vld_q || (data_in != last_val_q));
    pop        = valid_q && out_ready;
    full       = (count_q == CW'(DEPTH));
    loss       = push_req && full && !pop;
`ifdef CHANGE_CAPTURE_FIFO_OVERWRITE_EN
    // On loss the oldest entry is retired so the new value always lands.
    wr_en      = push_req;
    rd_adv     = pop || loss;
`else
    wr_en      = push_req && !loss;
    rd_adv     = pop;
`endif
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    last_val_d = last_val_q;
    last_vld_d = last_vld_q;
    ovf_d      = ovf_q;

    if (rd_adv) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    case ({wr_en, rd_adv})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Track the last seen value even when the entry is dropped, so no retries
    if (push_req) begin
      last_val_d = data_in;
      last_vld_d = 1'b1;
    end

    if (loss) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      last_val_q <= '0;
      last_vld_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[PW'(i)] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      last_val_q <= last_val_d;
      last_vld_q <= last_vld_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= data_in;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_change_capture_fifo.sv
// Scoreboard bench for change_capture_fifo (DEPTH=4); expectations follow the
// CHANGE_CAPTURE_FIFO_OVERWRITE_EN build macro when it is defined.
module tb_change_capture_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic [3:0]    data_in    = 4'h0;
  logic          capture_en = 1'b0;
  logic          clr_ovf    = 1'b0;
  logic          out_ready  = 1'b0;
  logic          out_valid;
  logic [3:0]    out_data;
  logic [CW-1:0] count;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  change_capture_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .capture_en (capture_en),
    .clr_ovf    (clr_ovf),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .count      (count),
    .overflow   (overflow)
  );

  // Scoreboard consumer: every handshake that the next edge will complete
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: out_data=%h popped with no entry expected", out_data);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL scoreboard_data: out_data=%h expected=%h", out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture_seq(input logic [3:0] v);
    capture_en = 1'b1;
    data_in    = v;
    tick();
  endtask

  // Enables the consumer until the scoreboard empties or the budget runs out
  task automatic run_drain(input int max_cyc, output int cyc);
    cyc        = 0;
    capture_en = 1'b0;
    out_ready  = 1'b1;
    while (exp_q.size() != 0 && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b1;
    tick();
    tick();
    n_checks += 3;
    if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    rst = 1'b0;
    exp_q.push_back(4'h0);
    capture_seq(4'h0);
    n_checks++;
    if (count !== CW'(1)) begin n_fail++; $display("FAIL first_capture_count: got %0d want 1", count); end
    tick(); tick(); tick();
    n_checks += 3;
    if (count !== CW'(1)) begin n_fail++; $display("FAIL first_capture_hold: got %0d want 1", count); end
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_capture_valid: got %b want 1", out_valid); end
    if (out_data !== 4'h0) begin n_fail++; $display("FAIL first_capture_data: got %h want 0", out_data); end
    run_drain(10, cyc);
    n_checks += 2;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL first_drain_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_change_filter();
    logic [3:0] seq [6] = '{4'h3, 4'h3, 4'h5, 4'h5, 4'h5, 4'hA};
    int cyc;
    exp_q.push_back(4'h3);
    exp_q.push_back(4'h5);
    exp_q.push_back(4'hA);
    for (int i = 0; i < 6; i++) capture_seq(seq[i]);
    n_checks++;
    if (count !== CW'(3)) begin n_fail++; $display("FAIL filter_count: got %0d want 3", count); end
    run_drain(10, cyc);
    n_checks += 3;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL filter_drain_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
    if (cyc != 3) begin n_fail++; $display("FAIL filter_drain_cycles: got %0d want 3", cyc); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL filter_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_full_drop();
    int cyc;
`ifdef CHANGE_CAPTURE_FIFO_OVERWRITE_EN
    exp_q = '{4'h2, 4'h3, 4'h4, 4'h5};
`else
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4};
`endif
    for (int v = 1; v <= 5; v++) capture_seq(4'(v));
    n_checks += 2;
    if (count !== CW'(4)) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf: got %b want 1", overflow); end
    run_drain(10, cyc);
    n_checks += 3;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
    if (cyc != 4) begin n_fail++; $display("FAIL full_drain_cycles: got %0d want 4", cyc); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_ovf_priority();
    int cyc;
`ifdef CHANGE_CAPTURE_FIFO_OVERWRITE_EN
    exp_q = '{4'h8, 4'h9, 4'hA, 4'hB};
`else
    exp_q = '{4'h7, 4'h8, 4'h9, 4'hA};
`endif
    for (int v = 7; v <= 10; v++) capture_seq(4'(v));
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL prio_pre_ovf: got %b want 0", overflow); end
    clr_ovf = 1'b1;
    capture_seq(4'hB);
    n_checks += 2;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL prio_set_wins: got %b want 1", overflow); end
    if (count !== CW'(4)) begin n_fail++; $display("FAIL prio_count: got %0d want 4", count); end
    capture_en = 1'b0;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL prio_clear: got %b want 0", overflow); end
    run_drain(10, cyc);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL prio_drain_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_full_pop();
    int cyc;
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
    for (int v = 1; v <= 4; v++) capture_seq(4'(v));
    out_ready = 1'b1;
    capture_seq(4'h6);
    out_ready  = 1'b0;
    capture_en = 1'b0;
    n_checks += 3;
    if (count !== CW'(4)) begin n_fail++; $display("FAIL fullpop_count: got %0d want 4", count); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    if (out_data !== 4'h2) begin n_fail++; $display("FAIL fullpop_head: got %h want 2", out_data); end
    run_drain(10, cyc);
    n_checks += 2;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL fullpop_drain_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
    if (cyc != 4) begin n_fail++; $display("FAIL fullpop_drain_cycles: got %0d want 4", cyc); end
  endtask

  task automatic test_backpressure();
    int cyc;
    exp_q = '{4'h9, 4'hC};
    capture_seq(4'h9);
    capture_seq(4'hC);
    capture_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks += 2;
      if (out_data !== 4'h9) begin n_fail++; $display("FAIL bp_data cycle %0d: got %h want 9", i, out_data); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cycle %0d: got %b want 1", i, out_valid); end
    end
    run_drain(10, cyc);
    n_checks += 2;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
    if (cyc != 2) begin n_fail++; $display("FAIL bp_drain_cycles: got %0d want 2", cyc); end
  endtask

  task automatic test_overwrite();
    int cyc;
`ifdef CHANGE_CAPTURE_FIFO_OVERWRITE_EN
    exp_q = '{4'h3, 4'h4, 4'h5, 4'h6};
`else
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4};
`endif
    for (int v = 1; v <= 6; v++) capture_seq(4'(v));
    n_checks += 2;
    if (count !== CW'(4)) begin n_fail++; $display("FAIL ovw_count: got %0d want 4", count); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovw_ovf: got %b want 1", overflow); end
    run_drain(10, cyc);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovw_drain_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    exp_q = '{4'h5, 4'h7};
    capture_seq(4'h5);
    capture_seq(4'h7);
    capture_en = 1'b0;
    n_checks++;
    if (count !== CW'(2)) begin n_fail++; $display("FAIL rstmid_pre_count: got %0d want 2", count); end
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    n_checks += 3;
    if (count !== '0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", count); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
    exp_q.push_back(4'h7);
    capture_seq(4'h7);
    capture_en = 1'b0;
    n_checks += 2;
    if (count !== CW'(1)) begin n_fail++; $display("FAIL rstmid_recapture: got %0d want 1", count); end
    if (out_data !== 4'h7) begin n_fail++; $display("FAIL rstmid_data: got %h want 7", out_data); end
    run_drain(10, cyc);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_drain_timeout: %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_change_filter();
    test_full_drop();
    test_ovf_priority();
    test_full_pop();
    test_backpressure();
    test_overwrite();
    test_reset_mid();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
